// File: rtl/apb4_pkg.sv
// Shared APB4 definitions: transfer FSM state encoding and PPROT bit constants.
package apb4_pkg;

    // Encoding puts PSEL in bit 0 and PENABLE in bit 1 so both decode straight from flops.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b11
    } apb_state_e;

    localparam logic [2:0] PPROT_PRIVILEGED  = 3'b001;
    localparam logic [2:0] PPROT_NONSECURE   = 3'b010;
    localparam logic [2:0] PPROT_INSTRUCTION = 3'b100;

endpackage

// File: rtl/apb4_initiator.sv
// APB4 master: turns a valid/ready command into SETUP/ACCESS transfers and
// returns a one-cycle response, with an optional wait-state timeout.
module apb4_initiator
    import apb4_pkg::*;
#(
    parameter int PADDR_SIZE = 16,
    parameter int PDATA_SIZE = 32,
    parameter int TIMEOUT    = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [PADDR_SIZE-1:0]   cmd_addr,
    input  logic [PDATA_SIZE-1:0]   cmd_wdata,
    input  logic [PDATA_SIZE/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    output logic [PDATA_SIZE-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [PADDR_SIZE-1:0]   PADDR,
    output logic [PDATA_SIZE-1:0]   PWDATA,
    output logic [PDATA_SIZE/8-1:0] PSTRB,
    output logic [2:0]              PPROT,
    input  logic [PDATA_SIZE-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    apb_state_e                r_state;
    apb_state_e                w_next;
    logic                      w_accept;
    logic                      w_done;
    logic                      w_timeout_hit;
    logic                      r_pwrite;
    logic [PADDR_SIZE-1:0]     r_paddr;
    logic [PDATA_SIZE-1:0]     r_pwdata;
    logic [PDATA_SIZE/8-1:0]   r_pstrb;
    logic [2:0]                r_pprot;
    logic                      r_rsp_valid;
    logic [PDATA_SIZE-1:0]     r_rsp_rdata;
    logic                      r_rsp_err;
    logic                      r_rsp_timeout;

    assign w_accept = cmd_valid && cmd_ready;
    assign w_done   = (r_state == ACCESS) && PREADY;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = SETUP;
            SETUP:   w_next = ACCESS;
            ACCESS: begin
                if (PREADY)             w_next = w_accept ? SETUP : IDLE;
                else if (w_timeout_hit) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        PSEL      = r_state[0];
        PENABLE   = r_state[1];
        cmd_ready = !PRESET && ((r_state == IDLE) || w_done);
    end

    // Write data is held across reads; strobes are meaningless for reads and forced low.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
            r_pprot  <= '0;
        end else if (w_accept) begin
            r_pwrite <= cmd_write;
            r_paddr  <= cmd_addr;
            r_pprot  <= cmd_prot;
            if (cmd_write) begin
                r_pwdata <= cmd_wdata;
                r_pstrb  <= cmd_strb;
            end else begin
                r_pstrb  <= '0;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid   <= w_done || w_timeout_hit;
            r_rsp_rdata   <= (w_done && !r_pwrite) ? PRDATA : '0;
            r_rsp_err     <= w_done ? PSLVERR : w_timeout_hit;
            r_rsp_timeout <= w_timeout_hit;
        end
    end

    // Counter holds the current ACCESS cycle number; it stops at TIMEOUT rather than wrapping.
    if (TIMEOUT > 0) begin : g_timeout
        localparam int              CNT_W   = $clog2(TIMEOUT + 1);
        localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
        logic [CNT_W-1:0] r_wait_cnt;

        always_ff @(posedge PCLK or posedge PRESET) begin
            if (PRESET)
                r_wait_cnt <= '0;
            else if (r_state == SETUP)
                r_wait_cnt <= CNT_W'(1);
            else if ((r_state == ACCESS) && !PREADY && (r_wait_cnt != CNT_MAX))
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end

        assign w_timeout_hit = (r_state == ACCESS) && !PREADY && (r_wait_cnt == CNT_MAX);
    end else begin : g_no_timeout
        assign w_timeout_hit = 1'b0;
    end

    assign PWRITE      = r_pwrite;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign PSTRB       = r_pstrb;
    assign PPROT       = r_pprot;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb4_initiator.sv
// Directed bench for apb4_initiator (TIMEOUT=4): write, waited read, back-to-back,
// slave error, timeout abort vs. last-cycle completion, and mid-transfer reset.
module tb_apb4_initiator;
    import apb4_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [DW/8-1:0] cmd_strb;
    logic [2:0]    cmd_prot;
    logic          rsp_valid, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW/8-1:0] PSTRB;
    logic [2:0]    PPROT;
    logic [DW-1:0] PRDATA;
    logic          PREADY, PSLVERR;

    int n_pass  = 0;
    int n_total = 0;
    int n_acc;
    int k;
    logic acc;

    apb4_initiator #(.PADDR_SIZE(AW), .PDATA_SIZE(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial forever #5 PCLK = ~PCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW/8-1:0] s, input logic [2:0] p);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        cmd_prot  = p;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, cmd_ready}, 0);
        chk({tag, "_paddr"}, PADDR, 0);
        chk({tag, "_pwdata"}, PWDATA, 0);
        chk({tag, "_pstrb_pprot"}, {PSTRB, PPROT}, 0);
        chk({tag, "_rdata"}, rsp_rdata, 0);
    endtask

    initial begin
        PRESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; cmd_prot = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        #2;
        check_all_zero("reset");
        tick; tick;
        PRESET = 1'b0;
        #1;
        chk("rst_release_ready", cmd_ready, 1);

        // Write, zero wait states
        PREADY = 1'b1;
        set_cmd(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, PPROT_PRIVILEGED);
        #1;
        chk("wr_ready_N", cmd_ready, 1);
        chk("wr_psel_N", PSEL, 0);
        tick; cmd_valid = 1'b0;
        chk("wr_setup_sel_en", {PSEL, PENABLE}, 2'b10);
        chk("wr_setup_paddr", PADDR, 16'h0010);
        chk("wr_setup_pwrite", PWRITE, 1);
        chk("wr_setup_pstrb", PSTRB, 4'hF);
        chk("wr_setup_pprot", PPROT, 3'b001);
        chk("wr_setup_rsp", rsp_valid, 0);
        tick;
        chk("wr_access_sel_en", {PSEL, PENABLE}, 2'b11);
        chk("wr_access_pwdata", PWDATA, 32'hDEADBEEF);
        chk("wr_access_pstrb", PSTRB, 4'hF);
        tick;
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_err_to", {rsp_err, rsp_timeout}, 2'b00);
        chk("wr_rsp_rdata", rsp_rdata, 0);
        chk("wr_idle_sel_en", {PSEL, PENABLE}, 2'b00);
        tick;
        chk("wr_rsp_single", rsp_valid, 0);

        // Read with three wait states
        PREADY = 1'b0;
        PRDATA = 32'h12345678;
        set_cmd(1'b0, 16'h0024, 32'h0BAD0BAD, 4'hF, 3'b000);
        #1;
        tick; cmd_valid = 1'b0;
        chk("rd_setup_sel_en", {PSEL, PENABLE}, 2'b10);
        chk("rd_setup_pstrb", PSTRB, 0);
        chk("rd_setup_pwrite", PWRITE, 0);
        chk("rd_pwdata_held", PWDATA, 32'hDEADBEEF);
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if ({PSEL, PENABLE} != 2'b11) break;
            n_acc++;
            chk($sformatf("rd_paddr_a%0d", i + 1), PADDR, 16'h0024);
            chk($sformatf("rd_pstrb_a%0d", i + 1), PSTRB, 0);
            if (i < 3) chk($sformatf("rd_ready_wait_a%0d", i + 1), cmd_ready, 0);
            if (i == 3) PREADY = 1'b1;
        end
        chk("rd_access_cycles", n_acc, 4);
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_rdata", rsp_rdata, 32'h12345678);
        chk("rd_rsp_err_to", {rsp_err, rsp_timeout}, 2'b00);
        tick;

        // Back-to-back: three writes, cmd_valid held
        PREADY = 1'b1;
        k = 0;
        set_cmd(1'b1, 16'h0100, 32'h11111111, 4'h1, 3'b000);
        #1;
        for (int c = 1; c <= 7; c++) begin
            acc = cmd_valid && cmd_ready;
            tick;
            if (acc) begin
                k++;
                if (k < 3) set_cmd(1'b1, 16'h0100 + 16'(k * 4), 32'h11111111 * (k + 1), 4'h1, 3'b000);
                else       cmd_valid = 1'b0;
            end
            chk($sformatf("b2b_psel_c%0d", c), PSEL, (c <= 6));
            chk($sformatf("b2b_penable_c%0d", c), PENABLE, ((c % 2 == 0) && (c <= 6)));
            chk($sformatf("b2b_rsp_c%0d", c), rsp_valid, ((c == 3) || (c == 5) || (c == 7)));
            if ((c % 2 == 1) && (c <= 5))
                chk($sformatf("b2b_paddr_c%0d", c), PADDR, 16'h0100 + 16'((c - 1) * 2));
        end
        chk("b2b_accepts", k, 3);
        tick;

        // Slave error on a read
        PSLVERR = 1'b1;
        PRDATA  = 32'hA5A5A5A5;
        set_cmd(1'b0, 16'h0030, 32'h0, 4'hF, PPROT_NONSECURE);
        #1;
        tick; cmd_valid = 1'b0;
        chk("err_setup_pprot", PPROT, 3'b010);
        tick; tick;
        chk("err_rsp_valid", rsp_valid, 1);
        chk("err_rsp_err_to", {rsp_err, rsp_timeout}, 2'b10);
        chk("err_rsp_rdata", rsp_rdata, 32'hA5A5A5A5);
        PSLVERR = 1'b0;
        tick;

        // Timeout: PREADY never rises
        PREADY = 1'b0;
        PRDATA = 32'hCAFEF00D;
        set_cmd(1'b0, 16'h0040, 32'h0, 4'h0, 3'b000);
        #1;
        tick; cmd_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick;
            chk($sformatf("to_access_a%0d", i), {PSEL, PENABLE}, 2'b11);
            chk($sformatf("to_norsp_a%0d", i), rsp_valid, 0);
        end
        chk("to_abort_ready", cmd_ready, 0);
        tick;
        chk("to_drop_sel_en", {PSEL, PENABLE}, 2'b00);
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err_to", {rsp_err, rsp_timeout}, 2'b11);
        chk("to_rsp_rdata", rsp_rdata, 0);
        tick;
        chk("to_rsp_single", rsp_valid, 0);
        chk("to_idle_ready", cmd_ready, 1);

        // PREADY on the 4th ACCESS cycle completes normally
        set_cmd(1'b0, 16'h0044, 32'h0, 4'h0, 3'b000);
        #1;
        tick; cmd_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick;
            if (i == 4) PREADY = 1'b1;
            chk($sformatf("to4_access_a%0d", i), {PSEL, PENABLE}, 2'b11);
        end
        #1;
        chk("to4_ready_last", cmd_ready, 1);
        tick;
        chk("to4_rsp_valid", rsp_valid, 1);
        chk("to4_rsp_err_to", {rsp_err, rsp_timeout}, 2'b00);
        chk("to4_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
        tick;

        // Reset during the 2nd ACCESS cycle
        PREADY = 1'b0;
        set_cmd(1'b0, 16'h0050, 32'h0, 4'h0, PPROT_INSTRUCTION);
        #1;
        tick; cmd_valid = 1'b0;
        tick;
        tick;
        chk("mid_access2", {PSEL, PENABLE}, 2'b11);
        PRESET = 1'b1;
        #1;
        check_all_zero("rst_mid");
        PREADY = 1'b1;
        tick;
        chk("rst_no_rsp", rsp_valid, 0);
        chk("rst_held_psel", PSEL, 0);
        PRESET = 1'b0;
        #1;
        chk("rst2_release_ready", cmd_ready, 1);
        PRDATA = 32'h0F0F0F0F;
        set_cmd(1'b0, 16'h0060, 32'h0, 4'h0, 3'b000);
        #1;
        tick; cmd_valid = 1'b0;
        chk("post_rst_setup_paddr", PADDR, 16'h0060);
        tick; tick;
        chk("post_rst_rsp_valid", rsp_valid, 1);
        chk("post_rst_rsp_rdata", rsp_rdata, 32'h0F0F0F0F);
        chk("post_rst_rsp_err", rsp_err, 0);
        tick;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/apb4_initiator.md
# apb4_initiator

APB4 master (initiator) that converts a simple valid/ready command port into compliant APB4 SETUP/ACCESS transfers. It waits for the slave's PREADY and returns read data or error status on a single-cycle response strobe. It drives the master side of the APB bus, upstream of the slave-select/response mux, and completes the bus end opposite to slave decode. A programmable wait-state timeout keeps a hung slave from stalling the bus.

## Interface
Parameters:
- PADDR_SIZE, 16, address width
- PDATA_SIZE, 32, data width; multiple of 8
- TIMEOUT, 0, max ACCESS cycles before abort; 0 = no timeout

Ports (all synchronous to PCLK):
- PCLK  in  1  bus clock
- PRESET  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  PADDR_SIZE  transfer address
- cmd_wdata  in  PDATA_SIZE  write data
- cmd_strb  in  PDATA_SIZE/8  write byte strobes
- cmd_prot  in  3  PPROT value
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  PDATA_SIZE  read data; 0 for writes and timeouts
- rsp_err  out  1  PSLVERR or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL, PENABLE, PWRITE  out  1  APB4 control
- PADDR  out  PADDR_SIZE; PWDATA  out  PDATA_SIZE; PSTRB  out  PDATA_SIZE/8; PPROT  out  3
- PRDATA  in  PDATA_SIZE; PREADY  in  1; PSLVERR  in  1

## Operation
- FSM states:
  - IDLE: PSEL=0, PENABLE=0.
  - SETUP: PSEL=1, PENABLE=0; lasts exactly 1 cycle; always moves to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1; held until PREADY or timeout.
- cmd_ready = !PRESET & (IDLE | (ACCESS & PREADY)).
- Accept in IDLE: go to SETUP. Register PADDR, PWRITE, PWDATA, PSTRB and PPROT from the cmd_* inputs.
- Accept in ACCESS (PREADY=1): go directly to SETUP with the new command. This is back-to-back operation with no IDLE cycle.
- PSTRB is forced to 0 for reads. PWDATA holds its last value on reads.
- Address and control signals are stable from SETUP through the last ACCESS cycle.
- Completion: ACCESS with PREADY=1. On the next cycle:
  - rsp_valid=1
  - rsp_err=PSLVERR
  - rsp_rdata=PRDATA for reads, 0 for writes
  - rsp_timeout=0
- Timeout (TIMEOUT>0):
  - Wait counter loads 1 on the first ACCESS cycle and increments each ACCESS cycle with PREADY=0.
  - ACCESS cycle number TIMEOUT with PREADY=0: go to IDLE and drop PSEL/PENABLE.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - cmd_ready stays 0 on the abort cycle.
- PREADY=1 on the TIMEOUT-th cycle is a normal completion, not a timeout.
- Counter width is $clog2(TIMEOUT+1). The counter saturates and never wraps.
- The response port has no backpressure. The consumer must accept rsp_valid when it fires.

## Timing
- Reset (asynchronous, any state including mid-ACCESS): state goes to IDLE immediately.
  - All outputs go to 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, rsp_valid, rsp_rdata, rsp_err, rsp_timeout.
  - cmd_ready=0.
  - The in-flight transfer is dropped and produces no response.
- First cycle after reset release: cmd_ready=1.
- Latency with zero wait states: accept at cycle N; SETUP at N+1; ACCESS at N+2; rsp_valid at N+3.
- Each PREADY=0 cycle adds one cycle of latency.
- Peak throughput is 1 transfer per 2 cycles.
- All outputs are registered except cmd_ready.
- cmd_ready depends combinationally on PREADY.

## Structure
- Shared package apb4_pkg holds:
  - state enum {IDLE, SETUP, ACCESS}
  - PPROT bit constants (privileged, non-secure, instruction)
- A separate sub-module is not warranted. The FSM, capture registers and timeout counter live in one module.
- The timeout counter and its logic are generated only when TIMEOUT>0.

## Test plan
- Write: addr=0x10, wdata=0xDEADBEEF, strb=0xF, PREADY=1 → PSEL rises at N+1, PENABLE at N+2. Then rsp_valid=1 with rsp_err=0 at N+3, and PSTRB=0xF throughout.
- Read: addr=0x24, slave holds PREADY=0 for 3 cycles, then returns PRDATA=0x12345678 → ACCESS lasts 4 cycles, rsp_rdata=0x12345678, PSTRB=0, PADDR stable throughout.
- Back-to-back: cmd_valid held for 3 commands, PREADY=1 → pattern SETUP, ACCESS, SETUP, ACCESS, SETUP, ACCESS with no IDLE cycle, and 3 rsp_valid pulses 2 cycles apart.
- Error: read with PSLVERR=1 and PREADY=1 → rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT=4, PREADY held 0 → PSEL/PENABLE drop after 4 ACCESS cycles; response has rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with PREADY=1 on the 4th ACCESS cycle → normal completion.
- Reset: assert PRESET during the 2nd ACCESS cycle → all outputs 0 immediately and no rsp_valid. After release, cmd_ready=1 and a new read completes normally.
